// File: rtl/rv32im_csr_access_unit.sv
// Zicsr access sequencer: drives one CSR regfile port through read,
// read-modify-write and write, then returns the old value for rd.
module rv32im_csr_access_unit #(
  parameter int API_XLEN  = 32,
  parameter int CSR_WIDTH = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [2:0]           req_funct3_i,
  input  logic [CSR_WIDTH-1:0] req_csr_addr_i,
  input  logic [4:0]           req_rs1_idx_i,
  input  logic [API_XLEN-1:0]  req_rs1_val_i,
  input  logic [4:0]           req_rd_idx_i,
  input  logic [1:0]           priviledge_mode_i,
  output logic [CSR_WIDTH-1:0] csr_addr_o,
  output logic                 csr_read_en_o,
  output logic                 csr_write_en_o,
  output logic [API_XLEN-1:0]  csr_wdata_o,
  input  logic [API_XLEN-1:0]  csr_rdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [4:0]           rsp_rd_idx_o,
  output logic                 rsp_rd_we_o,
  output logic [API_XLEN-1:0]  rsp_rd_val_o,
  output logic                 rsp_illegal_o
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  typedef struct packed {
    logic [1:0]          op;
    logic [API_XLEN-1:0] src;
    logic [4:0]          rd;
    logic                wr;
  } req_t;

  state_t              state;
  req_t                req_q;
  logic [API_XLEN-1:0] old_q;

  logic [API_XLEN-1:0] req_src;
  logic                req_rd;
  logic                req_wr;
  logic                req_ill;

  assign req_ready_o = (state == IDLE);

  assign req_src = req_funct3_i[2]
                 ? API_XLEN'(req_rs1_idx_i)
                 : req_rs1_val_i;
  assign req_rd  = !(req_funct3_i[1:0] == 2'b01
                  && req_rd_idx_i == 5'd0);
  assign req_wr  = (req_funct3_i[1:0] == 2'b01)
                || (req_rs1_idx_i != 5'd0);
  assign req_ill = (req_funct3_i[1:0] == 2'b00)
                || (req_csr_addr_i[9:8] > priviledge_mode_i)
                || (req_wr && req_csr_addr_i[11:10] == 2'b11);

  function automatic logic [API_XLEN-1:0] merge(
    input logic [1:0]          op,
    input logic [API_XLEN-1:0] old,
    input logic [API_XLEN-1:0] src
  );
    logic [API_XLEN-1:0] w;
    unique case (1'b1)
      op == 2'b01: w = src;
      op == 2'b10: w = old | src;
      default:     w = old & ~src;
    endcase
    return w;
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= IDLE;
      req_q          <= '0;
      old_q          <= '0;
      csr_addr_o     <= '0;
      csr_read_en_o  <= 1'b0;
      csr_write_en_o <= 1'b0;
      csr_wdata_o    <= '0;
      rsp_valid_o    <= 1'b0;
      rsp_rd_idx_o   <= '0;
      rsp_rd_we_o    <= 1'b0;
      rsp_rd_val_o   <= '0;
      rsp_illegal_o  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            req_q.op   <= req_funct3_i[1:0];
            req_q.src  <= req_src;
            req_q.rd   <= req_rd_idx_i;
            req_q.wr   <= req_wr;
            old_q      <= '0;
            csr_addr_o <= req_csr_addr_i;
            if (req_ill) begin
              state         <= RESP;
              rsp_valid_o   <= 1'b1;
              rsp_illegal_o <= 1'b1;
              rsp_rd_idx_o  <= req_rd_idx_i;
              rsp_rd_we_o   <= 1'b0;
              rsp_rd_val_o  <= '0;
            end else if (req_rd) begin
              state         <= READ;
              csr_read_en_o <= 1'b1;
            end else begin
              // only CSRRW/I with rd=x0 skips the read
              state          <= WRITE;
              csr_write_en_o <= 1'b1;
              csr_wdata_o    <= merge(req_funct3_i[1:0], '0, req_src);
            end
          end
        end
        READ: begin
          csr_read_en_o <= 1'b0;
          old_q         <= csr_rdata_i;
          if (req_q.wr) begin
            state          <= WRITE;
            csr_write_en_o <= 1'b1;
            csr_wdata_o    <= merge(req_q.op, csr_rdata_i, req_q.src);
          end else begin
            state        <= RESP;
            rsp_valid_o  <= 1'b1;
            rsp_rd_idx_o <= req_q.rd;
            rsp_rd_we_o  <= (req_q.rd != 5'd0);
            rsp_rd_val_o <= csr_rdata_i;
          end
        end
        WRITE: begin
          state          <= RESP;
          csr_write_en_o <= 1'b0;
          csr_wdata_o    <= '0;
          rsp_valid_o    <= 1'b1;
          rsp_rd_idx_o   <= req_q.rd;
          rsp_rd_we_o    <= (req_q.rd != 5'd0);
          rsp_rd_val_o   <= old_q;
        end
        RESP: begin
          if (rsp_ready_i) begin
            state         <= IDLE;
            csr_addr_o    <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_rd_idx_o  <= '0;
            rsp_rd_we_o   <= 1'b0;
            rsp_rd_val_o  <= '0;
            rsp_illegal_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
